// File: rtl/pio_poll_master.sv
// Avalon-MM poller for an input PIO data register, forwarding only changed samples
// over valid/ready. Optional interrupt output is built when PIO_POLL_IRQ_EN is defined.
module pio_poll_master #(
    parameter int unsigned POLL_PERIOD  = 1000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef PIO_POLL_IRQ_EN
    input  logic              irq_mask,
    output logic              irq,
`endif
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun,
    input  logic              clear_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [15:0] POLL_RELOAD = 16'(POLL_PERIOD - 1);
    localparam logic [2:0]  LAT_LOAD    = 3'(READ_LATENCY);

    state_t             state_q, state_d;
    logic [15:0]        poll_cnt_q, poll_cnt_d;
    logic [2:0]         lat_cnt_q, lat_cnt_d;
    logic               avm_read_q, avm_read_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic [DATA_W-1:0]  last_sample_q, last_sample_d;
    logic               have_sample_q, have_sample_d;
    logic               data_valid_q, data_valid_d;
    logic               overrun_q, overrun_d;
    logic               sample_s;
    logic               fwd_s;
    logic [DATA_W-1:0]  sample_data_s;
    logic               readdata_unused_s;

    // Upper readdata bits are intentionally discarded.
    assign readdata_unused_s = ^avm_readdata;

    // State register and all datapath flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            poll_cnt_q    <= POLL_RELOAD;
            lat_cnt_q     <= 3'd0;
            avm_read_q    <= 1'b0;
            data_out_q    <= '0;
            last_sample_q <= '0;
            have_sample_q <= 1'b0;
            data_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            poll_cnt_q    <= poll_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            avm_read_q    <= avm_read_d;
            data_out_q    <= data_out_d;
            last_sample_q <= last_sample_d;
            have_sample_q <= have_sample_d;
            data_valid_q  <= data_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state logic: poll countdown, read handshake, latency countdown.
    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (poll_cnt_q == 16'd0) begin
                        state_d = ST_READ;
                    end else begin
                        poll_cnt_d = poll_cnt_q - 16'd1;
                    end
                end else begin
                    poll_cnt_d = poll_cnt_q;
                end
            end
            ST_READ: begin
                if (!avm_waitrequest) begin
                    state_d   = ST_WAIT;
                    lat_cnt_d = LAT_LOAD;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WAIT: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    state_d    = ST_IDLE;
                    poll_cnt_d = POLL_RELOAD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                poll_cnt_d = POLL_RELOAD;
                lat_cnt_d  = 3'd0;
            end
        endcase
    end

    // Output logic: bus request, change detection, handshake and overrun.
    always_comb begin
        avm_read_d    = (state_d == ST_READ);
        sample_s      = (state_q == ST_WAIT) && (lat_cnt_q == 3'd1);
        sample_data_s = avm_readdata[DATA_W-1:0];
        fwd_s         = sample_s && (!have_sample_q || (sample_data_s != last_sample_q));
        data_out_d    = data_out_q;
        last_sample_d = last_sample_q;
        have_sample_d = have_sample_q;
        data_valid_d  = data_valid_q;
        overrun_d     = overrun_q;
        if (fwd_s) begin
            data_out_d    = sample_data_s;
            last_sample_d = sample_data_s;
            have_sample_d = 1'b1;
            data_valid_d  = 1'b1;
        end else if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end
        // A set on the same edge as a clear takes priority.
        if (fwd_s && data_valid_q && !data_ready) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    assign avm_address = 2'b00;
    assign avm_read    = avm_read_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign overrun     = overrun_q;

`ifdef PIO_POLL_IRQ_EN
    logic irq_q;

    // Interrupt lags data_valid/overrun by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (data_valid_q | overrun_q) & irq_mask;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pio_poll_master.sv
// Scoreboard bench for pio_poll_master: expected consumed samples are queued by the
// stimulus and checked by a monitor on every valid/ready handshake.
module tb_pio_poll_master;

    localparam int PP = 4;
    localparam int RL = 1;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [1:0]    avm_address;
    logic          avm_read;
    logic          avm_waitrequest;
    logic [31:0]   avm_readdata;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;
    logic          overrun;
    logic          clear_overrun;
`ifdef PIO_POLL_IRQ_EN
    logic          irq_mask;
    logic          irq;
`endif

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    mon_exp;

    pio_poll_master #(.POLL_PERIOD(PP), .READ_LATENCY(RL), .DATA_W(DW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
`ifdef PIO_POLL_IRQ_EN
        .irq_mask        (irq_mask),
        .irq             (irq),
`endif
        .enable          (enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .overrun         (overrun),
        .clear_overrun   (clear_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_read(input int max, output int n);
        n = 0;
        while (avm_read !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        if (avm_read !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_read: got timeout after %0d cycles expected avm_read", n);
        end
    endtask

    task automatic wait_valid(input int max);
        int n;
        n = 0;
        while (data_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        if (data_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: got timeout after %0d cycles expected data_valid", n);
        end
    endtask

    task automatic consume();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        chk("valid_cleared", {31'd0, data_valid}, 32'd0);
    endtask

    // Monitor: every accepted handshake must match the next queued sample.
    always @(negedge clk) begin
        if (reset_n && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL monitor_unexpected: got 0x%0h expected no handshake", data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("monitor_data", {24'd0, data_out}, {24'd0, mon_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rises[$];
        logic prev;
        logic flag;

        reset_n         = 1'b0;
        enable          = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h0000_00A5;
        data_ready      = 1'b0;
        clear_overrun   = 1'b0;
`ifdef PIO_POLL_IRQ_EN
        irq_mask        = 1'b1;
`endif
        exp_q.push_back(8'hA5);
        repeat (3) tick();
        chk("rst_avm_read", {31'd0, avm_read}, 32'd0);
        chk("rst_avm_address", {30'd0, avm_address}, 32'd0);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);

        // First read begins on the 4th edge after release.
        reset_n = 1'b1;
        wait_read(20, n);
        chk("first_read_delay", n, 32'd4);
        tick();
        chk("read_dropped", {31'd0, avm_read}, 32'd0);
        chk("valid_before_sample", {31'd0, data_valid}, 32'd0);
        tick();
        chk("valid_after_sample", {31'd0, data_valid}, 32'd1);
        chk("data_a5", {24'd0, data_out}, 32'h0000_00A5);
        flag = 1'b1;
        repeat (3) begin
            tick();
            flag = flag & data_valid & (data_out == 8'hA5);
        end
        chk("hold_until_ready", {31'd0, flag}, 32'd1);
        consume();

        // Unchanged data: reads every 6 cycles, no new valid.
        prev = avm_read;
        flag = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (avm_read && !prev) rises.push_back(i);
            prev = avm_read;
            if (data_valid) flag = 1'b1;
        end
        chk("no_redundant_valid", {31'd0, flag}, 32'd0);
        chk("read_pulse_count", rises.size(), 32'd3);
        for (int k = 0; k < rises.size(); k++) chk("read_period", rises[k], 6 * (k + 1));

        // Waitrequest stall for 5 cycles.
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'h0000_005A;
        exp_q.push_back(8'h5A);
        flag = 1'b1;
        repeat (5) begin
            tick();
            flag = flag & avm_read & (avm_address == 2'b00);
        end
        chk("stall_stable", {31'd0, flag}, 32'd1);
        avm_waitrequest = 1'b0;
        tick();
        chk("stall_accept", {31'd0, avm_read}, 32'd0);
        tick();
        chk("stall_sample_valid", {31'd0, data_valid}, 32'd1);
        chk("stall_sample_data", {24'd0, data_out}, 32'h0000_005A);
        consume();

        // Overrun: 0x11 is overwritten by 0x22 before it is consumed.
        avm_readdata = 32'h0000_0011;
        exp_q.push_back(8'h22);
        wait_valid(20);
        chk("ovr_first_data", {24'd0, data_out}, 32'h0000_0011);
        chk("ovr_not_yet", {31'd0, overrun}, 32'd0);
        avm_readdata = 32'h0000_0022;
        n = 0;
        while (data_out !== 8'h22 && n < 20) begin
            tick();
            n++;
        end
        chk("ovr_second_data", {24'd0, data_out}, 32'h0000_0022);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_valid", {31'd0, data_valid}, 32'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);
        chk("ovr_valid_kept", {31'd0, data_valid}, 32'd1);
        consume();

        // Upper bits ignored; enable dropped during WAIT.
        avm_readdata = 32'hFFFF_FF3C;
        exp_q.push_back(8'h3C);
        wait_read(20, n);
        tick();
        chk("wait_entered", {31'd0, avm_read}, 32'd0);
        enable = 1'b0;
        tick();
        chk("dis_sample_valid", {31'd0, data_valid}, 32'd1);
        chk("dis_sample_data", {24'd0, data_out}, 32'h0000_003C);
        consume();
        flag = 1'b0;
        repeat (12) begin
            tick();
            if (avm_read) flag = 1'b1;
        end
        chk("disabled_no_read", {31'd0, flag}, 32'd0);
        enable = 1'b1;
        wait_read(20, n);
        chk("reenable_delay", n, 32'd4);

        // Asynchronous reset mid-read, then 0x00 must still be forwarded.
        avm_readdata = 32'h0000_0000;
        exp_q.push_back(8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_read", {31'd0, avm_read}, 32'd0);
        chk("async_rst_valid", {31'd0, data_valid}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        wait_valid(30);
        chk("zero_forwarded", {31'd0, data_valid}, 32'd1);
        chk("zero_data", {24'd0, data_out}, 32'd0);
        consume();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
